mem_arbiter: RTL and testbench

Shares the single data-side access path of the unified `memory` (write port plus read port 2) between NUM_REQ requesters: requester 0 is the core's load/store path, higher indices are auxiliary masters (program loader, DMA, debug). Fixed priority to requester 0 with a starvation guard; at most one access per cycle; read data is routed back one cycle after issue. Sits between `core`/aux masters and `memory` inside `top`; the instruction-fetch port (read port 1) bypasses it.

---
 rtl/mem_pkg.sv | 18 +
 rtl/prio_guard_sel.sv | 38 +++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and widths for the data-side memory arbiter.
package mem_pkg;

  localparam int XLEN      = 32;
  localparam int BYTE_EN_W = 4;

  typedef struct packed {
    logic                 we;
    logic [XLEN-1:0]      addr;
    logic [XLEN-1:0]      wdata;
    logic [BYTE_EN_W-1:0] be;
  } mem_req_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_guard_sel.sv
// Fixed-priority one-hot select; mask0 removes requester 0 from contention
// so the starvation guard can hand the slot to an auxiliary master.
module prio_guard_sel
  import mem_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               mask0,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id,
  output logic               gnt_valid
);

  logic [NUM_REQ-1:0] eligible;

  always_comb begin
    eligible    = req;
    eligible[0] = req[0] & ~mask0;
  end

  // Scan from the top down so the lowest eligible index is the last to win.
  always_comb begin
    gnt       = '0;
    gnt_id    = '0;
    gnt_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        gnt       = '0;
        gnt[i]    = 1'b1;
        gnt_id    = IDW'(i);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared data-side memory path (write port + read port 2)
// between the core load/store unit (requester 0) and auxiliary masters.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*XLEN-1:0]      req_addr,
  input  logic [NUM_REQ*XLEN-1:0]      req_wdata,
  input  logic [NUM_REQ*BYTE_EN_W-1:0] req_be,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [NUM_REQ-1:0]           rvalid,
  output logic [XLEN-1:0]              rdata,
  output logic [XLEN-1:0]              mem_addr2,
  output logic                         mem_wr_en,
  output logic [XLEN-1:0]              mem_wr_addr,
  output logic [XLEN-1:0]              mem_wr_data,
  output logic [BYTE_EN_W-1:0]         mem_byte_en,
  input  logic [XLEN-1:0]              mem_rd_data2
);

  // Handshake: req[i] is a level held with its fields stable until gnt[i];
  // gnt[i] is combinational in the same cycle and is the issue point. A read
  // answers with a one-cycle rvalid[i] exactly one cycle later; writes complete
  // at gnt. Holding req after gnt issues another access.

  localparam int         IDW      = id_width(NUM_REQ);
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  mem_req_t           reqs [NUM_REQ];
  mem_req_t           sel;
  logic [NUM_REQ-1:0] req_live;
  logic               others;
  logic               mask0;
  logic [IDW-1:0]     gnt_id;
  logic               gnt_valid;
  logic               rd_issue;

  logic [7:0]         hold_cnt;
  logic               rd_pend;
  logic [IDW-1:0]     rd_id;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      reqs[i].we    = req_we[i];
      reqs[i].addr  = req_addr[i*XLEN +: XLEN];
      reqs[i].wdata = req_wdata[i*XLEN +: XLEN];
      reqs[i].be    = req_be[i*BYTE_EN_W +: BYTE_EN_W];
    end
  end

  // Nothing is granted while reset is held, whatever the requesters do.
  assign req_live = rst ? '0 : req;
  assign others   = |req_live[NUM_REQ-1:1];
  assign mask0    = others && (hold_cnt == HOLD_MAX);

  prio_guard_sel #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_sel (
    .req       (req_live),
    .mask0     (mask0),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    sel = '0;
    if (gnt_valid) sel = reqs[gnt_id];
  end

  assign mem_wr_en   = gnt_valid & sel.we;
  assign mem_wr_addr = sel.addr;
  assign mem_addr2   = sel.addr;
  assign mem_wr_data = sel.wdata;
  assign mem_byte_en = sel.be;
  assign rd_issue    = gnt_valid & ~sel.we;

  // Counts consecutive requester-0 wins that happened while someone else waited.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (gnt_valid && (gnt_id != '0)) begin
      hold_cnt <= '0;
    end else if (!others) begin
      hold_cnt <= '0;
    end else if (gnt[0] && (hold_cnt != HOLD_MAX)) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_id   <= '0;
    end else begin
      rd_pend <= rd_issue;
      if (rd_issue) rd_id <= gnt_id;
    end
  end

  // Gating with rst drops a response that would land in a reset cycle.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (rd_pend && !rst) begin
      rvalid[rd_id] = 1'b1;
      rdata         = mem_rd_data2;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table vectors, directed corner
// sequences and randomized traffic against a behavioural arbitration model.
module tb_mem_arbiter;

  localparam int NUM_REQ  = 2;
  localparam int MAX_HOLD = 8;
  localparam int W        = 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ-1:0]    req_we = '0;
  logic [NUM_REQ*W-1:0]  req_addr = '0;
  logic [NUM_REQ*W-1:0]  req_wdata = '0;
  logic [NUM_REQ*4-1:0]  req_be = '0;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rvalid;
  logic [W-1:0]          rdata;
  logic [W-1:0]          mem_addr2;
  logic                  mem_wr_en;
  logic [W-1:0]          mem_wr_addr;
  logic [W-1:0]          mem_wr_data;
  logic [3:0]            mem_byte_en;
  logic [W-1:0]          mem_rd_data2;

  always #5 clk = ~clk;

  mem_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_be       (req_be),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .mem_addr2    (mem_addr2),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_byte_en  (mem_byte_en),
    .mem_rd_data2 (mem_rd_data2)
  );

  // Memory stand-in: 256 words, one-cycle read latency, byte-enabled writes.
  logic [W-1:0] mem [256];
  logic         bd_we = 1'b0;
  logic [7:0]   bd_addr = '0;
  logic [W-1:0] bd_data = '0;

  function automatic logic [W-1:0] merge(logic [W-1:0] old, logic [W-1:0] d, logic [3:0] be);
    logic [W-1:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    mem_rd_data2 <= mem[mem_addr2[9:2]];
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_wr_en) mem[mem_wr_addr[9:2]] <= merge(mem[mem_wr_addr[9:2]], mem_wr_data, mem_byte_en);
  end

  // Scoreboard and reference state.
  logic [W-1:0] shadow [256];
  logic [W-1:0] exp_q[$];
  int           exp_id_q[$];
  int           m_streak = 0;
  int           checks = 0;
  int           failures = 0;

  logic [NUM_REQ-1:0] s_gnt, s_rvalid;
  logic [W-1:0]       s_rdata, s_wr_addr;
  logic               s_wr_en;
  logic [3:0]         s_be;

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_req(int i, bit on, bit we, logic [W-1:0] a, logic [W-1:0] d, logic [3:0] be);
    req[i]               = on;
    req_we[i]            = we;
    req_addr[i*W +: W]   = a;
    req_wdata[i*W +: W]  = d;
    req_be[i*4 +: 4]     = be;
  endtask

  task automatic idle_reqs();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Called at a falling edge with inputs already driven; checks then advances.
  task automatic cycle();
    int           win;
    bit           others;
    logic [NUM_REQ-1:0] egnt, erv;
    logic [W-1:0] erd, ea, ed;
    logic [3:0]   ebe;
    logic         ewe;
    logic [W-1:0] d;
    int           id;
    #1;
    others = 1'b0;
    for (int i = 1; i < NUM_REQ; i++) if (req[i]) others = 1'b1;
    win = -1;
    if (!rst) begin
      if (req[0] && !(others && m_streak >= MAX_HOLD)) win = 0;
      else for (int i = 1; i < NUM_REQ; i++) if (req[i] && win < 0) win = i;
    end
    egnt = '0; ea = '0; ed = '0; ebe = '0; ewe = 1'b0;
    if (win >= 0) begin
      egnt[win] = 1'b1;
      ea  = req_addr[win*W +: W];
      ed  = req_wdata[win*W +: W];
      ebe = req_be[win*4 +: 4];
      ewe = req_we[win];
    end
    erv = '0; erd = '0;
    if (exp_q.size() > 0) begin
      d  = exp_q.pop_front();
      id = exp_id_q.pop_front();
      if (!rst) begin
        erv[id] = 1'b1;
        erd     = d;
      end
    end
    check("gnt", W'(gnt), W'(egnt));
    check("mem_wr_en", W'(mem_wr_en), W'(ewe));
    check("mem_wr_addr", mem_wr_addr, ea);
    check("mem_addr2", mem_addr2, ea);
    check("mem_wr_data", mem_wr_data, ed);
    check("mem_byte_en", W'(mem_byte_en), W'(ebe));
    check("rvalid", W'(rvalid), W'(erv));
    check("rdata", rdata, erd);
    check("hold_cnt", W'(dut.hold_cnt), W'(m_streak));
    s_gnt = gnt; s_rvalid = rvalid; s_rdata = rdata;
    s_wr_en = mem_wr_en; s_wr_addr = mem_wr_addr; s_be = mem_byte_en;
    if (rst) begin
      m_streak = 0;
    end else begin
      if (win >= 0) begin
        if (ewe) shadow[ea[9:2]] = merge(shadow[ea[9:2]], ed, ebe);
        else begin
          exp_q.push_back(shadow[ea[9:2]]);
          exp_id_q.push_back(win);
        end
      end
      if (win == 0 && others) m_streak = (m_streak < MAX_HOLD) ? m_streak + 1 : MAX_HOLD;
      else m_streak = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic poke(logic [7:0] wa, logic [W-1:0] data);
    bd_we = 1'b1; bd_addr = wa; bd_data = data;
    shadow[wa] = data;
    idle_reqs();
    cycle();
    bd_we = 1'b0;
  endtask

  typedef struct {
    logic [1:0]   r;
    logic [1:0]   we;
    logic [W-1:0] a0;
    logic [W-1:0] a1;
    logic [1:0]   exp_gnt;
    logic         exp_wr_en;
    logic [W-1:0] exp_addr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{2'b00, 2'b00, 32'h10, 32'h20, 2'b00, 1'b0, 32'h0};
    vecs[1] = '{2'b01, 2'b01, 32'h10, 32'h20, 2'b01, 1'b1, 32'h10};
    vecs[2] = '{2'b10, 2'b00, 32'h10, 32'h24, 2'b10, 1'b0, 32'h24};
    vecs[3] = '{2'b11, 2'b10, 32'h14, 32'h28, 2'b01, 1'b0, 32'h14};
    vecs[4] = '{2'b11, 2'b10, 32'h18, 32'h2C, 2'b01, 1'b0, 32'h18};
    vecs[5] = '{2'b10, 2'b10, 32'h1C, 32'h30, 2'b10, 1'b1, 32'h30};
    vecs[6] = '{2'b01, 2'b00, 32'h33, 32'h34, 2'b01, 1'b0, 32'h33};

    @(negedge clk);
    // Preload memory and its shadow while the arbiter sits in reset.
    for (int k = 0; k < 256; k++) begin
      bd_we = 1'b1; bd_addr = 8'(k); bd_data = $urandom;
      shadow[k] = bd_data;
      @(negedge clk);
    end
    bd_we = 1'b0;
    @(negedge clk);

    // Reset with both requesters active.
    rst = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h40, '0, 4'hF);
    set_req(1, 1'b1, 1'b0, 32'h44, '0, 4'hF);
    cycle();
    check("rst_gnt", W'(s_gnt), 32'h0);
    cycle();
    check("rst_rvalid", W'(s_rvalid), 32'h0);
    rst = 1'b0;
    cycle();
    check("post_rst_gnt", W'(s_gnt), 32'h1);
    idle_reqs();
    cycle();

    // Table vectors.
    for (int v = 0; v < 7; v++) begin
      set_req(0, vecs[v].r[0], vecs[v].we[0], vecs[v].a0, ~vecs[v].a0, 4'hF);
      set_req(1, vecs[v].r[1], vecs[v].we[1], vecs[v].a1, ~vecs[v].a1, 4'hF);
      cycle();
      check("vec_gnt", W'(s_gnt), W'(vecs[v].exp_gnt));
      check("vec_wr_en", W'(s_wr_en), W'(vecs[v].exp_wr_en));
      check("vec_addr", s_wr_addr, vecs[v].exp_addr);
    end
    idle_reqs();
    cycle();

    // Single read by requester 1.
    poke(8'h40, 32'hDEADBEEF);
    set_req(1, 1'b1, 1'b0, 32'h100, '0, 4'hF);
    cycle();
    check("single_gnt", W'(s_gnt), 32'h2);
    check("single_rv0", W'(s_rvalid), 32'h0);
    idle_reqs();
    cycle();
    check("single_rvalid", W'(s_rvalid), 32'h2);
    check("single_rdata", s_rdata, 32'hDEADBEEF);

    // Byte write then readback.
    poke(8'h81, 32'hA5A5A5A5);
    set_req(0, 1'b1, 1'b1, 32'h204, 32'h11223344, 4'b0010);
    cycle();
    check("bw_wr_en", W'(s_wr_en), 32'h1);
    check("bw_addr", s_wr_addr, 32'h204);
    check("bw_be", W'(s_be), 32'h2);
    set_req(0, 1'b1, 1'b0, 32'h204, '0, 4'hF);
    cycle();
    idle_reqs();
    cycle();
    check("bw_readback", s_rdata, 32'hA5A533A5);

    // Starvation guard with both requesters reading continuously.
    for (int k = 0; k < 27; k++) begin
      set_req(0, 1'b1, 1'b0, 32'($urandom_range(0, 255)) << 2, '0, 4'hF);
      set_req(1, 1'b1, 1'b0, 32'($urandom_range(0, 255)) << 2, '0, 4'hF);
      cycle();
      check("starve_gnt", W'(s_gnt), (k % 9 == 8) ? 32'h2 : 32'h1);
    end
    idle_reqs();
    cycle();

    // Pipelined reads alternating requesters.
    poke(8'h00, 32'h0BAD0000);
    poke(8'h01, 32'h0BAD0004);
    poke(8'h02, 32'h0BAD0008);
    set_req(0, 1'b1, 1'b0, 32'h0, '0, 4'hF);
    cycle();
    idle_reqs();
    set_req(1, 1'b1, 1'b0, 32'h4, '0, 4'hF);
    cycle();
    check("pipe_rv_a", W'(s_rvalid), 32'h1);
    check("pipe_rd_a", s_rdata, 32'h0BAD0000);
    idle_reqs();
    set_req(0, 1'b1, 1'b0, 32'h8, '0, 4'hF);
    cycle();
    check("pipe_rv_b", W'(s_rvalid), 32'h2);
    check("pipe_rd_b", s_rdata, 32'h0BAD0004);
    idle_reqs();
    cycle();
    check("pipe_rv_c", W'(s_rvalid), 32'h1);
    check("pipe_rd_c", s_rdata, 32'h0BAD0008);

    // Reset arriving the cycle after a read grant.
    set_req(1, 1'b1, 1'b0, 32'h100, '0, 4'hF);
    cycle();
    rst = 1'b1;
    set_req(0, 1'b1, 1'b1, 32'h10, 32'h1, 4'hF);
    set_req(1, 1'b1, 1'b0, 32'h14, '0, 4'hF);
    cycle();
    check("midrst_rvalid", W'(s_rvalid), 32'h0);
    check("midrst_gnt", W'(s_gnt), 32'h0);
    check("midrst_wr_en", W'(s_wr_en), 32'h0);
    rst = 1'b0;
    idle_reqs();
    cycle();
    check("midrst_after", W'(s_rvalid), 32'h0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < NUM_REQ; i++)
        set_req(i, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                32'($urandom_range(0, 1023)), $urandom, 4'($urandom_range(0, 15)));
      cycle();
    end
    rst = 1'b0;
    idle_reqs();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
